// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg -- shared types and helpers for the scan decoder.
//   state_t : FSM state encoding (IDLE, DIRECT, SCAN).
//   onehot  : returns a vector with only bit idx set, or all-zero when idx is
//             outside the 2**w_bits output range. The result is ONEHOT_MAX bits
//             wide; callers cast it down to their own output width.
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // Widest select the helper supports.
   localparam int MAX_W_BITS = 8;
   localparam int ONEHOT_MAX = 2 ** MAX_W_BITS;

   function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [MAX_W_BITS-1:0] idx,
                                                    input int unsigned           w_bits);
      logic [ONEHOT_MAX-1:0] r;
      r = '0;
      if (32'(idx) < (32'd1 << w_bits))
         r[idx] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if -- select/enable inputs and decoded outputs of scan_decoder.
//   W    : direct select index            (master -> slave)
//   En   : enable, 0 forces outputs low   (master -> slave)
//   mode : 0 direct decode, 1 auto-scan   (master -> slave)
//   Y    : registered one-hot output      (slave -> master)
//   idx  : index currently driven on Y    (slave -> master)
//   wrap : one-cycle pulse on scan wrap   (slave -> master)
interface scan_decoder_if #(
   parameter int W_BITS = 3
);
   logic [W_BITS-1:0]      W;
   logic                   En;
   logic                   mode;
   logic [2**W_BITS-1:0]   Y;
   logic [W_BITS-1:0]      idx;
   logic                   wrap;

   modport master (output W, En, mode, input Y, idx, wrap);
   modport slave  (input W, En, mode, output Y, idx, wrap);
endinterface

// File: rtl/dwell_counter.sv
// dwell_counter -- counts 0..DWELL-1 while en is high, then wraps to 0.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears the count
//   clr : synchronous clear, clears the count
//   en  : advance the count this cycle (hold otherwise)
//   tc  : high when en is set and the count sits at DWELL-1, i.e. the
//         edge that returns the count to 0
module dwell_counter #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_p0;

   assign tc = en && (cnt_p0 == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt_p0 <= '0;
      else if (en) begin
         if (cnt_p0 == LAST)
            cnt_p0 <= '0;
         else
            cnt_p0 <= cnt_p0 + 1'b1;
      end
   end
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder -- registered one-hot decoder with optional auto-scan.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : scan_decoder_if slave (W, En, mode in; Y, idx, wrap out)
// Parameters: W_BITS select width (Y is 2**W_BITS wide), DWELL cycles per
// scan position (1..65535).
// Build option: define SCAN_DECODER_SCAN_EN to compile in the SCAN state,
// the dwell counter and the wrap pulse. Without it, mode is ignored, the FSM
// only uses IDLE/DIRECT and wrap is tied low.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int W_BITS = 3,
   parameter int DWELL  = 4
) (
   input  logic          clk,
   input  logic          rst,
   scan_decoder_if.slave bus
);
   localparam int OUT_W = 2 ** W_BITS;

   state_t              state_p0, ns;
   logic [W_BITS-1:0]   idx_p0, idx_n;
   logic [OUT_W-1:0]    y_p0, y_n;
   logic                wrap_p0, wrap_n;

`ifdef SCAN_DECODER_SCAN_EN
   logic                cnt_clr, cnt_en, cnt_tc;
   logic [W_BITS-1:0]   idx_inc;

   assign idx_inc = idx_p0 + 1'b1;

   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (cnt_tc)
   );
`else
   logic unused_mode;
   assign unused_mode = bus.mode;
`endif

   always_comb begin
      idx_n  = idx_p0;
      wrap_n = 1'b0;
      y_n    = '0;
`ifdef SCAN_DECODER_SCAN_EN
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      ns = bus.En ? (bus.mode ? SCAN : DIRECT) : IDLE;
`else
      ns = bus.En ? DIRECT : IDLE;
`endif
      case (ns)
         DIRECT: idx_n = bus.W;
`ifdef SCAN_DECODER_SCAN_EN
         SCAN: begin
            if (state_p0 != SCAN) begin
               // Fresh entry (also after IDLE): restart from W with a full dwell.
               idx_n   = bus.W;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
               if (cnt_tc) begin
                  idx_n  = idx_inc;
                  wrap_n = (idx_inc == '0);
               end
            end
         end
`endif
         default: idx_n = idx_p0;   // IDLE: index frozen, outputs low
      endcase
      if (ns != IDLE)
         y_n = OUT_W'(onehot(MAX_W_BITS'(idx_n), W_BITS));
   end

   // Output register stage: every output comes from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= IDLE;
         idx_p0   <= '0;
         y_p0     <= '0;
         wrap_p0  <= 1'b0;
      end else begin
         state_p0 <= ns;
         idx_p0   <= idx_n;
         y_p0     <= y_n;
         wrap_p0  <= wrap_n;
      end
   end

   assign bus.Y    = y_p0;
   assign bus.idx  = idx_p0;
   assign bus.wrap = wrap_p0;
endmodule
